// File: rtl/dlx_pipe_pkg.sv
// rtl/dlx_pipe_pkg.sv - DLX decode field positions, instruction classes and the ID/EX bundle type
package dlx_pipe_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;

    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [4:0] OP_JTYPE_HI5 = 5'b00001;

    localparam int DLX_XLEN = 32;
    localparam int DLX_RAW  = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0800_0000;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_I,
        CLS_J
    } instr_class_e;

    typedef struct packed {
        logic [DLX_XLEN-1:0] instr;
        logic [DLX_XLEN-1:0] pc;
        logic [DLX_RAW-1:0]  rd;
        logic [DLX_RAW-1:0]  rs1;
        logic [DLX_RAW-1:0]  rs2;
        logic                is_load;
    } id_ex_t;

    function automatic instr_class_e instr_class(input logic [5:0] opcode);
        if (opcode == OP_RTYPE) begin
            return CLS_R;
        end else if (opcode[5:1] == OP_JTYPE_HI5) begin
            return CLS_J;
        end else begin
            return CLS_I;
        end
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register load-latency down-counters with two busy read ports
module load_scoreboard #(
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1,
    parameter int RAW      = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           set_en,
    input  logic [RAW-1:0] set_idx,
    input  logic           dec_en,
    input  logic [RAW-1:0] rd_idx_a,
    output logic           rd_busy_a,
    input  logic [RAW-1:0] rd_idx_b,
    output logic           rd_busy_b
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);

    logic [CW-1:0] cnt [NREGS];

    // A fresh load to a register overrides that register's decrement in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (set_en && (set_idx == RAW'(i))) begin
                    cnt[i] <= LAT_INIT;
                end else if (dec_en && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign rd_busy_a = (cnt[rd_idx_a] != '0);
    assign rd_busy_b = (cnt[rd_idx_b] != '0);

endmodule

// File: rtl/id_hazard_stage.sv
// rtl/id_hazard_stage.sv - DLX decode hazard control and ID/EX register; ID_HAZARD_STALL_CNT_EN enables stall_cnt
module id_hazard_stage
    import dlx_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1,
    localparam int RAW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_is_load,
    input  logic            id_wr_rd,
    input  logic [RAW-1:0]  id_rd,
    output logic            id_ready,
    input  logic            nullify,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [RAW-1:0]  ex_rd,
    output logic [RAW-1:0]  ex_rs1,
    output logic [RAW-1:0]  ex_rs2,
    output logic            ex_is_load,
    output logic            hazard,
    output logic [31:0]     stall_cnt
);

    instr_class_e   cls;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic           busy1;
    logic           busy2;
    logic           adv;
    logic           issue;
    logic           sb_set;
    logic           ex_valid_q;
    id_ex_t         ex_q;

    always_comb begin
        cls = instr_class(id_instr[OP_HI:OP_LO]);
        rs1 = '0;
        rs2 = '0;
        case (cls)
            CLS_R: begin
                rs1 = RAW'(id_instr[RS1_HI:RS1_LO]);
                rs2 = RAW'(id_instr[RS2_HI:RS2_LO]);
            end
            CLS_I: begin
                rs1 = RAW'(id_instr[RS1_HI:RS1_LO]);
            end
            default: begin
            end
        endcase
    end

    assign sb_set = issue & id_is_load & id_wr_rd & (id_rd != '0);

    load_scoreboard #(
        .NREGS    (NREGS),
        .LOAD_LAT (LOAD_LAT),
        .RAW      (RAW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (sb_set),
        .set_idx   (id_rd),
        .dec_en    (ex_ready),
        .rd_idx_a  (rs1),
        .rd_busy_a (busy1),
        .rd_idx_b  (rs2),
        .rd_busy_b (busy2)
    );

    assign hazard   = id_valid & (((rs1 != '0) & busy1) | ((rs2 != '0) & busy2));
    assign adv      = ex_ready | ~ex_valid_q;
    assign issue    = id_valid & ~hazard & ~nullify & adv;
    assign id_ready = ~id_valid | nullify | issue;

    // While EX holds (adv=0) the branch that raised nullify is still there, so the register just holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (adv) begin
            ex_valid_q    <= issue;
            ex_q.instr    <= DLX_XLEN'(id_instr);
            ex_q.pc       <= DLX_XLEN'(id_pc);
            ex_q.rd       <= id_wr_rd ? DLX_RAW'(id_rd) : '0;
            ex_q.rs1      <= DLX_RAW'(rs1);
            ex_q.rs2      <= DLX_RAW'(rs2);
            ex_q.is_load  <= id_is_load;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_instr   = XLEN'(ex_q.instr);
    assign ex_pc      = XLEN'(ex_q.pc);
    assign ex_rd      = RAW'(ex_q.rd);
    assign ex_rs1     = RAW'(ex_q.rs1);
    assign ex_rs2     = RAW'(ex_q.rs2);
    assign ex_is_load = ex_q.is_load;

`ifdef ID_HAZARD_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (hazard && !nullify && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/id_hazard_stage.md
Name: id_hazard_stage

Overview:
- Parametrised decode-stage hazard controller plus ID/EX pipeline register for the DLX pipeline.
- Replaces NOP substitution with a per-register load scoreboard supporting LOAD_LAT bubble cycles.
- Adds valid/ready back-pressure from EX and branch nullification.
- Sits between the IF/ID register and the EX stage; the decoder stays external and feeds the decoded rd and load flags in.

Parameters:
- XLEN, 32, width of PC and instruction word.
- NREGS, 32, architectural register count (index width RAW = $clog2(NREGS)).
- LOAD_LAT, 1, bubbles required between a load and a dependent consumer (1..7).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- id_valid, in, 1, instruction present in ID.
- id_instr, in, XLEN, raw instruction word.
- id_pc, in, XLEN, PC of the ID instruction.
- id_is_load, in, 1, decoded instruction is a load.
- id_wr_rd, in, 1, decoded instruction writes rd.
- id_rd, in, RAW, decoded destination register.
- id_ready, out, 1, ID instruction consumed this cycle; IF may advance.
- nullify, in, 1, taken branch from EX; kill the ID instruction.
- ex_ready, in, 1, EX accepts ex_* this cycle.
- ex_valid, out, 1, ex_* holds a real instruction.
- ex_instr, out, XLEN, issued instruction word.
- ex_pc, out, XLEN, issued PC.
- ex_rd, out, RAW, issued destination register (0 if no write).
- ex_rs1, out, RAW, issued first source register.
- ex_rs2, out, RAW, issued second source register.
- ex_is_load, out, 1, issued instruction is a load.
- hazard, out, 1, combinational load-use hazard flag on the current ID instruction.
- stall_cnt, out, 32, hazard stall-cycle count (optional feature).

Behaviour:
- Source extraction from id_instr (DLX formats):
  - opcode[31:26]==0 (R-type): rs1=[25:21], rs2=[20:16].
  - opcode[31:27]==5'b00001 (J-type): no sources.
  - Otherwise (I-type): rs1=[25:21], rs2=0.
  - Index 0 never counts as a hazard.
- Scoreboard: one down-counter per register, width $clog2(LOAD_LAT+1).
  - Issue of a load with id_wr_rd=1 and id_rd!=0 sets cnt[id_rd]=LOAD_LAT.
  - Every cycle with ex_ready=1, all nonzero counters decrement by 1.
  - If set and decrement hit the same entry in one cycle, set wins.
- hazard = id_valid & ((rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0)).
- adv = ex_ready | !ex_valid.
- issue = id_valid & !hazard & !nullify & adv.
- id_ready = !id_valid | nullify | issue. A nullified instruction is consumed and dropped.
- ID/EX register update:
  - When adv=1: ex_valid<=issue and the ex_* fields load from ID. ex_rd is forced to 0 when id_wr_rd=0.
  - When adv=0: all ex_* fields hold.
  - nullify forces ex_valid<=0 when adv=1. When adv=0, nullify is ignored for ex_* (the branch is still in EX).
- Latency: one cycle from ID to EX when unstalled. A load followed by a dependent instruction costs exactly LOAD_LAT bubble cycles, given ex_ready=1.
- Reset (asynchronous, any time): ex_valid=0, all ex_* fields=0, all counters=0, stall_cnt=0. The first cycle after reset issues normally.
- A bubble is ex_valid=0. Field contents during a bubble are don't-care but must be stable.

Optional Feature:
- Macro: ID_HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each cycle with hazard=1 & !nullify, saturating at 32'hFFFF_FFFF. Cleared only by reset.
- Undefined: no counter logic is generated and stall_cnt is tied to 0.

Decomposition:
- Package dlx_pipe_pkg:
  - opcode field positions and the R/J opcode constants.
  - typedef instr_class_e {CLS_R, CLS_I, CLS_J}.
  - NOP_INSTR = 32'h0800_0000.
  - typedef id_ex_t for the ex_* bundle.
- Sub-module load_scoreboard: counter array with set/decrement ports and two combinational read ports.

Test Plan:
- Load r3, then add r4,r3,r5, ex_ready=1, LOAD_LAT=1 -> hazard=1 for 1 cycle, one bubble (ex_valid=0), add issues on cycle 2. With ID_HAZARD_STALL_CNT_EN, stall_cnt=1.
- Same sequence with LOAD_LAT=3 -> exactly 3 bubbles. A load to r0 followed by a use of r0 -> 0 bubbles.
- Load r7, then J-type (opcode 00001x) with [25:21]=7 -> no hazard, issues next cycle.
- ex_ready=0 for 4 cycles with a valid load in EX -> ex_* stable, id_ready=0, scoreboard frozen. Dependent instruction stalls until LOAD_LAT cycles with ex_ready=1 have elapsed.
- nullify=1 with id_valid=1, adv=1 -> id_ready=1, next ex_valid=0, no scoreboard set even if the ID instruction is a load.
- Assert reset mid-stall (counter=1) -> outputs cleared immediately. After deassert, the dependent instruction issues with no bubble.
